// File: rtl/scale_down_sequencer.sv
// scale_down_sequencer
//
// Frame-level controller for the bilinear scale-down path. On frame_start it
// latches the input/output resolutions, checks them for legality, computes the
// 16.16 horizontal and vertical scale factors with a 32-cycle restoring
// divider each, then walks the output raster one row at a time. Each row waits
// until the line buffer reports that the two source rows it needs are
// resident.
//
// Optional feature macro: SCALE_SEQ_UPSCALE_EN
//   defined   : vout > vin is accepted (scale factors below 1.0 are produced).
//   undefined : vout > vin raises cfg_err.
//
// Ports
//   vin_clk                  pixel clock (only clock)
//   rst                      synchronous active-high reset
//   frame_start              one-cycle pulse beginning (or restarting) a frame
//   vin_xres, vin_yres       input resolution, sampled on frame_start
//   vout_xres, vout_yres     output resolution, sampled on frame_start
//   line_ready               line buffer holds rows line_req_y and line_req_y+1
//   out_ready                downstream accepts the current coordinate
//   scaler_width/height      16.16 scale factors, (vin << 16) / vout
//   vout_x, vout_y           current output coordinate
//   coord_valid              vout_x/vout_y are valid
//   line_req_y               source row needed for the current vout_y
//   line_req                 waiting for line_ready
//   busy                     sequencer is not idle
//   frame_done               one-cycle pulse at the end of a frame
//   cfg_err                  sticky illegal-configuration flag
//
// All outputs come straight from flops; the status flags are registered from
// the next-state value so they line up with the state they describe.

module scale_down_sequencer (
  input  logic        vin_clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [15:0] vin_xres,
  input  logic [15:0] vin_yres,
  input  logic [15:0] vout_xres,
  input  logic [15:0] vout_yres,
  input  logic        line_ready,
  input  logic        out_ready,
  output logic [31:0] scaler_width,
  output logic [31:0] scaler_height,
  output logic [15:0] vout_x,
  output logic [15:0] vout_y,
  output logic        coord_valid,
  output logic [15:0] line_req_y,
  output logic        line_req,
  output logic        busy,
  output logic        frame_done,
  output logic        cfg_err
);

  typedef enum logic [2:0] {
    StIdle,
    StDivW,
    StDivH,
    StLineCalc,
    StWaitLine,
    StRun,
    StLineEnd,
    StDone
  } state_e;

  state_e      state_q, state_d;

  // vin_xres is only needed as the first dividend, which div_q captures.
  logic [15:0] vin_yres_q, vin_yres_d;
  logic [15:0] vout_xres_q, vout_xres_d;
  logic [15:0] vout_yres_q, vout_yres_d;

  // Divider: div_q shifts the dividend out of the MSB while quotient bits
  // shift in at the LSB; rem_q is the partial remainder (always < divisor).
  logic [31:0] div_q, div_d;
  logic [15:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [31:0] scaler_width_q, scaler_width_d;
  logic [31:0] scaler_height_q, scaler_height_d;
  logic [15:0] vout_x_q, vout_x_d;
  logic [15:0] vout_y_q, vout_y_d;
  logic [15:0] line_req_y_q, line_req_y_d;
  logic        coord_valid_q, coord_valid_d;
  logic        line_req_q, line_req_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        cfg_err_q, cfg_err_d;

  // ---------------------------------------------------------------------------
  // Configuration legality (evaluated on the raw inputs at frame_start)
  // ---------------------------------------------------------------------------
  logic cfg_bad;

`ifdef SCALE_SEQ_UPSCALE_EN
  assign cfg_bad = (vout_xres == 16'd0) || (vout_yres == 16'd0) ||
                   (vin_xres < 16'd2) || (vin_yres < 16'd2);
`else
  assign cfg_bad = (vout_xres == 16'd0) || (vout_yres == 16'd0) ||
                   (vin_xres < 16'd2) || (vin_yres < 16'd2) ||
                   (vout_xres > vin_xres) || (vout_yres > vin_yres);
`endif

  // ---------------------------------------------------------------------------
  // Restoring divider step
  // ---------------------------------------------------------------------------
  logic [15:0] divisor;
  logic [16:0] rem_shift;
  logic [16:0] rem_sub;
  logic        q_bit;
  logic [15:0] rem_next;
  logic [31:0] div_next;

  always_comb begin
    divisor   = (state_q == StDivH) ? vout_yres_q : vout_xres_q;
    rem_shift = {rem_q, div_q[31]};
    rem_sub   = rem_shift - {1'b0, divisor};
    // rem_shift < 2*divisor, so bit 16 of the difference is exactly the borrow.
    q_bit     = ~rem_sub[16];
    rem_next  = q_bit ? rem_sub[15:0] : rem_shift[15:0];
    div_next  = {div_q[30:0], q_bit};
  end

  // ---------------------------------------------------------------------------
  // Source row: srcY = (((vout_y << 1) + 1) * scaler_height - 1) >> 1, 48 bits
  // ---------------------------------------------------------------------------
  logic [47:0] src_prod;
  logic [47:0] src_int;
  logic [47:0] src_limit;
  logic [15:0] src_row;

  always_comb begin
    src_prod  = {31'd0, vout_y_q, 1'b1} * {16'd0, scaler_height_q};
    // >> 1 for the formula, >> 16 more for the integer part.
    src_int   = (src_prod - 48'd1) >> 17;
    src_limit = {32'd0, vin_yres_q} - 48'd1;
    // Keep row+1 inside the frame: clamp to the last pair of source rows.
    src_row   = (src_int >= src_limit) ? (vin_yres_q - 16'd2) : src_int[15:0];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    vin_yres_d      = vin_yres_q;
    vout_xres_d     = vout_xres_q;
    vout_yres_d     = vout_yres_q;
    div_d           = div_q;
    rem_d           = rem_q;
    cnt_d           = cnt_q;
    scaler_width_d  = scaler_width_q;
    scaler_height_d = scaler_height_q;
    vout_x_d        = vout_x_q;
    vout_y_d        = vout_y_q;
    line_req_y_d    = line_req_y_q;
    cfg_err_d       = cfg_err_q;

    unique case (state_q)
      StIdle: begin
      end

      StDivW: begin
        div_d = div_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          scaler_width_d = div_next;
          div_d          = {vin_yres_q, 16'h0000};
          rem_d          = 16'd0;
          cnt_d          = 5'd0;
          state_d        = StDivH;
        end
      end

      StDivH: begin
        div_d = div_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          scaler_height_d = div_next;
          vout_y_d        = 16'd0;
          state_d         = StLineCalc;
        end
      end

      StLineCalc: begin
        line_req_y_d = src_row;
        state_d      = StWaitLine;
      end

      StWaitLine: begin
        if (line_ready) begin
          vout_x_d = 16'd0;
          state_d  = StRun;
        end
      end

      StRun: begin
        if (coord_valid_q && out_ready) begin
          if (vout_x_q == vout_xres_q - 16'd1) begin
            state_d = StLineEnd;
          end else begin
            vout_x_d = vout_x_q + 16'd1;
          end
        end
      end

      StLineEnd: begin
        if (vout_y_q == vout_yres_q - 16'd1) begin
          state_d = StDone;
        end else begin
          vout_y_d = vout_y_q + 16'd1;
          state_d  = StLineCalc;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // frame_start wins over whatever the current state wanted: a frame in
    // flight is abandoned without frame_done.
    if (frame_start) begin
      vin_yres_d  = vin_yres;
      vout_xres_d = vout_xres;
      vout_yres_d = vout_yres;
      if (cfg_bad) begin
        cfg_err_d = 1'b1;
        state_d   = StIdle;
      end else begin
        cfg_err_d = 1'b0;
        div_d     = {vin_xres, 16'h0000};
        rem_d     = 16'd0;
        cnt_d     = 5'd0;
        state_d   = StDivW;
      end
    end

    busy_d        = (state_d != StIdle);
    coord_valid_d = (state_d == StRun);
    line_req_d    = (state_d == StWaitLine);
    frame_done_d  = (state_d == StDone);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge vin_clk) begin
    if (rst) begin
      state_q         <= StIdle;
      vin_yres_q      <= '0;
      vout_xres_q     <= '0;
      vout_yres_q     <= '0;
      div_q           <= '0;
      rem_q           <= '0;
      cnt_q           <= '0;
      scaler_width_q  <= '0;
      scaler_height_q <= '0;
      vout_x_q        <= '0;
      vout_y_q        <= '0;
      line_req_y_q    <= '0;
      coord_valid_q   <= 1'b0;
      line_req_q      <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      vin_yres_q      <= vin_yres_d;
      vout_xres_q     <= vout_xres_d;
      vout_yres_q     <= vout_yres_d;
      div_q           <= div_d;
      rem_q           <= rem_d;
      cnt_q           <= cnt_d;
      scaler_width_q  <= scaler_width_d;
      scaler_height_q <= scaler_height_d;
      vout_x_q        <= vout_x_d;
      vout_y_q        <= vout_y_d;
      line_req_y_q    <= line_req_y_d;
      coord_valid_q   <= coord_valid_d;
      line_req_q      <= line_req_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      cfg_err_q       <= cfg_err_d;
    end
  end

  assign scaler_width  = scaler_width_q;
  assign scaler_height = scaler_height_q;
  assign vout_x        = vout_x_q;
  assign vout_y        = vout_y_q;
  assign coord_valid   = coord_valid_q;
  assign line_req_y    = line_req_y_q;
  assign line_req      = line_req_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign cfg_err       = cfg_err_q;

endmodule
